// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID/EX sequencing - load-use stall, redirect squash, MUL/DIV occupancy FSM
// Ports: clk, rst_n (async active-low); ID read ports (id_rf_re*, id_rf_p*_addr);
//   EX info (ex_dm_re, ex_rf_we, ex_rf_dst_addr, ex_mul_div, ex_redirect);
//   front-end controls (pc_hold, if_id_hold, if_id_flush, id_ex_stall, ex_mem_bubble);
//   MUL/DIV strobes (md_start, md_busy, md_wb_valid).
module hazard_stall_ctrl #(
  parameter int MD_LAT = 4,
  localparam int CNT_W = $clog2(MD_LAT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_rf_re0,
  input  logic       id_rf_re1,
  input  logic [4:0] id_rf_p0_addr,
  input  logic [4:0] id_rf_p1_addr,
  input  logic       ex_dm_re,
  input  logic       ex_rf_we,
  input  logic [4:0] ex_rf_dst_addr,
  input  logic       ex_mul_div,
  input  logic       ex_redirect,
  output logic       pc_hold,
  output logic       if_id_hold,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       ex_mem_bubble,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_wb_valid
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_LAT - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] md_cnt, cnt_nxt;
  logic issue, busy, redir, load_use, hazard;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_cnt  <= cnt_nxt;
      md_busy <= state_nxt != IDLE;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt   = md_cnt;
    case (state)
      IDLE: begin
        state_nxt = ex_mul_div ? BUSY : IDLE;
        cnt_nxt   = ex_mul_div ? CNT_W'(1) : md_cnt;
      end
      BUSY: begin
        state_nxt = md_cnt == LAST ? DONE : BUSY;
        cnt_nxt   = md_cnt == LAST ? '0 : md_cnt + CNT_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign hazard = ex_dm_re && ex_rf_we && ex_rf_dst_addr != 5'd0 &&
                  ((id_rf_re0 && id_rf_p0_addr == ex_rf_dst_addr) ||
                   (id_rf_re1 && id_rf_p1_addr == ex_rf_dst_addr));
  // Priority: MUL/DIV issue/occupancy, then redirect (ID instr is wrong-path), then load-use.
  always_comb begin
    issue         = rst_n && state == IDLE && ex_mul_div;
    busy          = rst_n && state == BUSY;
    redir         = rst_n && !issue && !busy && ex_redirect;
    load_use      = rst_n && !issue && !busy && !redir && hazard;
    pc_hold       = issue || busy || load_use;
    if_id_hold    = issue || busy || load_use;
    if_id_flush   = redir;
    id_ex_stall   = issue || busy || redir || load_use;
    ex_mem_bubble = issue;
    md_start      = issue;
    md_wb_valid   = rst_n && state == DONE;
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: random + directed checks of two hazard_stall_ctrl instances against a timeline model
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic id_rf_re0, id_rf_re1, ex_dm_re, ex_rf_we, ex_mul_div, ex_redirect;
  logic [4:0] id_rf_p0_addr, id_rf_p1_addr, ex_rf_dst_addr;
  logic [7:0] v4, v2;
  int tests = 0, fails = 0, cyc = 0, iss4 = -1, iss2 = -1;
  bit run = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  hazard_stall_ctrl #(.MD_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rf_re0(id_rf_re0), .id_rf_re1(id_rf_re1),
    .id_rf_p0_addr(id_rf_p0_addr), .id_rf_p1_addr(id_rf_p1_addr), .ex_dm_re(ex_dm_re),
    .ex_rf_we(ex_rf_we), .ex_rf_dst_addr(ex_rf_dst_addr), .ex_mul_div(ex_mul_div),
    .ex_redirect(ex_redirect), .pc_hold(v4[7]), .if_id_hold(v4[6]), .if_id_flush(v4[5]),
    .id_ex_stall(v4[4]), .ex_mem_bubble(v4[3]), .md_start(v4[2]), .md_busy(v4[1]),
    .md_wb_valid(v4[0]));
  hazard_stall_ctrl #(.MD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_rf_re0(id_rf_re0), .id_rf_re1(id_rf_re1),
    .id_rf_p0_addr(id_rf_p0_addr), .id_rf_p1_addr(id_rf_p1_addr), .ex_dm_re(ex_dm_re),
    .ex_rf_we(ex_rf_we), .ex_rf_dst_addr(ex_rf_dst_addr), .ex_mul_div(ex_mul_div),
    .ex_redirect(ex_redirect), .pc_hold(v2[7]), .if_id_hold(v2[6]), .if_id_flush(v2[5]),
    .id_ex_stall(v2[4]), .ex_mem_bubble(v2[3]), .md_start(v2[2]), .md_busy(v2[1]),
    .md_wb_valid(v2[0]));
  // Model: a MUL/DIV issued at cycle iss holds the front end for lat cycles (elapsed 0..lat-1),
  // writes back at elapsed==lat and is busy for elapsed 1..lat.
  function automatic logic [7:0] model(input int lat, input int iss, input int c, output bit issue);
    int e = c - iss;
    bit idle, holdmd, done, haz, red, lu, hold;
    idle   = iss < 0 || e > lat;
    holdmd = !idle && e < lat;
    done   = !idle && e == lat;
    haz    = ex_dm_re && ex_rf_we && ex_rf_dst_addr != 0 &&
             ((id_rf_re0 && id_rf_p0_addr == ex_rf_dst_addr) ||
              (id_rf_re1 && id_rf_p1_addr == ex_rf_dst_addr));
    issue  = rst_n && idle && ex_mul_div;
    red    = !issue && !holdmd && ex_redirect;
    lu     = !issue && !holdmd && !red && haz;
    hold   = issue || holdmd || lu;
    if (!rst_n) return 8'h00;
    return {hold, hold, red, hold || red, issue, issue, !idle && e >= 1, done};
  endfunction
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %b want %b", nm, cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    bit i4, i2;
    logic [7:0] e4, e2;
    if (run) begin
      e4 = model(4, iss4, cyc, i4);
      e2 = model(2, iss2, cyc, i2);
      chk("model_lat4", v4, e4);
      chk("model_lat2", v2, e2);
      if (!rst_n) begin
        iss4 = -1;
        iss2 = -1;
      end
      if (i4) iss4 = cyc;
      if (i2) iss2 = cyc;
    end
  end
  task automatic clr();
    {id_rf_re0, id_rf_re1, ex_dm_re, ex_rf_we, ex_mul_div, ex_redirect} = '0;
    id_rf_p0_addr = 0;
    id_rf_p1_addr = 0;
    ex_rf_dst_addr = 0;
  endtask
  task automatic step4(input string nm, input logic [7:0] exp);
    @(negedge clk);
    chk(nm, v4, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic step2(input string nm, input logic [7:0] exp);
    @(negedge clk);
    chk(nm, v2, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    run = 1;
    repeat (2) @(posedge clk);
    #1;
    step4("reset_zero", 8'h00);
    rst_n = 1'b1;
    step4("idle_zero", 8'h00);
    ex_dm_re = 1; ex_rf_we = 1; ex_rf_dst_addr = 5; id_rf_re1 = 1; id_rf_p1_addr = 5;
    step4("load_use", 8'hD0);
    clr();
    step4("load_use_clear", 8'h00);
    ex_dm_re = 1; ex_rf_we = 1; ex_rf_dst_addr = 0; id_rf_re0 = 1; id_rf_p0_addr = 0;
    step4("x0_no_hazard", 8'h00);
    clr();
    ex_dm_re = 1; ex_rf_we = 1; ex_rf_dst_addr = 5; id_rf_re1 = 0; id_rf_p1_addr = 5;
    step4("unread_port", 8'h00);
    id_rf_re1 = 1; ex_redirect = 1;
    step4("redirect_over_lu", 8'h30);
    clr();
    ex_mul_div = 1;
    step4("md_issue", 8'hDC);
    ex_mul_div = 0;
    repeat (3) step4("md_busy", 8'hD2);
    step4("md_wb", 8'h03);
    step4("md_after", 8'h00);
    repeat (2) step4("settle", 8'h00);
    ex_mul_div = 1;
    step4("rst_issue", 8'hDC);
    ex_mul_div = 0;
    step4("rst_busy1", 8'hD2);
    rst_n = 1'b0;
    step4("rst_mid_busy", 8'h00);
    rst_n = 1'b1;
    repeat (6) step4("rst_no_wb", 8'h00);
    ex_mul_div = 1;
    step2("b2b_issue0", 8'hDC);
    ex_mul_div = 0;
    step2("b2b_busy0", 8'hD2);
    step2("b2b_wb0", 8'h03);
    ex_mul_div = 1;
    step2("b2b_issue1", 8'hDC);
    ex_mul_div = 0;
    step2("b2b_busy1", 8'hD2);
    step2("b2b_wb1", 8'h03);
    repeat (6) step2("b2b_idle", 8'h00);
    repeat (800) begin
      id_rf_re0      = 1'($urandom);
      id_rf_re1      = 1'($urandom);
      id_rf_p0_addr  = 5'($urandom_range(0, 3));
      id_rf_p1_addr  = 5'($urandom_range(0, 3));
      ex_dm_re       = 1'($urandom);
      ex_rf_we       = 1'($urandom);
      ex_rf_dst_addr = 5'($urandom_range(0, 3));
      ex_mul_div     = $urandom_range(0, 7) == 0;
      ex_redirect    = $urandom_range(0, 4) == 0;
      rst_n          = $urandom_range(0, 149) != 0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
